memory_burst_master: RTL

Initiator for the CPU's single-port word memory. Accepts burst read/write requests from the control state machine, sequences one memory word per cycle over the `rw_flag`/`address`/`write_memory_value`/`read_memory_value` interface, and streams data in and out with valid/ready handshakes. It sits between the core FSM and `memory_unit`, replacing ad-hoc direct memory drive.

---
 rtl/memory_burst_master_pkg.sv | 26 ++
 rtl/memory_burst_master.sv | 115 +++++++++++
 2 files changed

// File: rtl/memory_burst_master_pkg.sv
// Shared types for the burst master: memory access flag, burst FSM states,
// memory geometry and the wrapping address increment.
package memory_burst_master_pkg;

    localparam int REGSIZE = 32;
    localparam int MEMSIZE = 64;

    typedef enum logic {
        MEMORY_READ  = 1'b0,
        MEMORY_WRITE = 1'b1
    } MEMORY_FLAG_TYPE;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        WRITE,
        DONE
    } BURST_STATE_TYPE;

    // Word addresses wrap at the top of memory, not at the register width.
    function automatic logic [REGSIZE-1:0] next_addr(input logic [REGSIZE-1:0] a);
        return (a == REGSIZE'(MEMSIZE - 1)) ? '0 : a + 1'b1;
    endfunction

endpackage

// File: rtl/memory_burst_master.sv
// Burst initiator for the single-port word memory: one word per cycle,
// valid/ready streams on the data side, one-entry read holding register.
module memory_burst_master
    import memory_burst_master_pkg::*;
#(
    parameter int MAX_BURST = 8,
    parameter int LEN_W     = $clog2(MAX_BURST) + 1
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [REGSIZE-1:0]  req_address,
    input  logic [LEN_W-1:0]    req_length,
    input  logic                wdata_valid,
    output logic                wdata_ready,
    input  logic [REGSIZE-1:0]  wdata,
    output logic                rdata_valid,
    input  logic                rdata_ready,
    output logic [REGSIZE-1:0]  rdata,
    output logic                rdata_last,
    output logic                done,
    output MEMORY_FLAG_TYPE     rw_flag,
    output logic [REGSIZE-1:0]  address,
    output logic [REGSIZE-1:0]  write_memory_value,
    input  logic [REGSIZE-1:0]  read_memory_value
);

    BURST_STATE_TYPE     state;
    logic [REGSIZE-1:0]  cur_addr;
    logic [LEN_W-1:0]    remaining;
    logic [LEN_W-1:0]    len_sat;
    logic                slot_free;
    logic                last_word;

    assign len_sat   = (req_length > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : req_length;
    assign slot_free = !rdata_valid || rdata_ready;
    assign last_word = (remaining == LEN_W'(1));

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state       <= IDLE;
            cur_addr    <= '0;
            remaining   <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            rdata_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cur_addr  <= req_address;
                        remaining <= len_sat;
                        if (len_sat == '0)
                            state <= DONE;
                        else
                            state <= req_write ? WRITE : READ;
                    end
                end
                READ: begin
                    // A stalled consumer holds the word and freezes the fetch address.
                    if (slot_free) begin
                        rdata       <= read_memory_value;
                        rdata_valid <= 1'b1;
                        rdata_last  <= last_word;
                        cur_addr    <= next_addr(cur_addr);
                        remaining   <= remaining - 1'b1;
                        if (last_word)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (rdata_valid && rdata_ready) begin
                        rdata_valid <= 1'b0;
                        rdata_last  <= 1'b0;
                        state       <= DONE;
                    end
                end
                WRITE: begin
                    if (wdata_valid) begin
                        cur_addr  <= next_addr(cur_addr);
                        remaining <= remaining - 1'b1;
                        if (last_word)
                            state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready   = (state == IDLE);
    assign wdata_ready = (state == WRITE);
    assign done        = (state == DONE);

    // The write strobe follows wdata_valid combinationally so a word commits on its handshake edge.
    always_comb begin
        rw_flag            = MEMORY_READ;
        address            = '0;
        write_memory_value = '0;
        case (state)
            READ: address = cur_addr;
            WRITE: begin
                address            = cur_addr;
                write_memory_value = wdata;
                if (wdata_valid)
                    rw_flag = MEMORY_WRITE;
            end
            default: ;
        endcase
    end

endmodule
